// File: rtl/freqdiv_prog.sv
// freqdiv_prog: multi-channel programmable clock-enable divider with double-buffered settings
module freqdiv_prog #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 16,
  parameter int CHW        = 2,
  parameter int DEF_PERIOD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [WIDTH-1:0] wr_high,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);
  localparam logic [WIDTH-1:0] DP  = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] DH  = WIDTH'(DEF_PERIOD / 2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  logic [WIDTH-1:0] p_q[NCH], h_q[NCH], sp_q[NCH], sh_q[NCH], cnt_q[NCH];
  logic [WIDTH-1:0] p_d[NCH], h_d[NCH], sp_d[NCH], sh_d[NCH], cnt_d[NCH];
  logic [NCH-1:0] run_q, run_d, out_d, tick_d, pend_d, wr, cnting, bnd, apply;
  // shadow always equals active when nothing is pending, so applying is just copying the shadow
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr[i]     = wr_en && int'(wr_ch) == i;
      cnting[i] = run_q[i] && en[i];
      bnd[i]    = cnting[i] && (sync || cnt_q[i] == p_q[i] - ONE);
      apply[i]  = !cnting[i] || bnd[i];
      sp_d[i]   = wr[i] ? wr_period : sp_q[i];
      sh_d[i]   = wr[i] ? wr_high : sh_q[i];
      p_d[i]    = apply[i] ? sp_d[i] : p_q[i];
      h_d[i]    = apply[i] ? sh_d[i] : h_q[i];
      pend_d[i] = !apply[i] && (pending[i] || wr[i]);
      cnt_d[i]  = (cnting[i] && !bnd[i]) ? cnt_q[i] + ONE : '0;
      run_d[i]  = en[i] && p_d[i] >= TWO;
      tick_d[i] = bnd[i] && run_d[i];
      out_d[i]  = run_d[i] && cnt_d[i] < h_d[i];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        p_q[i]   <= DP;
        h_q[i]   <= DH;
        sp_q[i]  <= DP;
        sh_q[i]  <= DH;
        cnt_q[i] <= '0;
      end
      run_q   <= '0;
      out     <= '0;
      tick    <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        p_q[i]   <= p_d[i];
        h_q[i]   <= h_d[i];
        sp_q[i]  <= sp_d[i];
        sh_q[i]  <= sh_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      run_q   <= run_d;
      out     <= out_d;
      tick    <= tick_d;
      pending <= pend_d;
    end
  end
endmodule

// File: tb/tb_freqdiv_prog.sv
// tb_freqdiv_prog: randomized and directed check of freqdiv_prog against a cycle model
module tb_freqdiv_prog;
  localparam int NCH = 3;
  logic clk = 0, reset = 0, sync = 0, wr_en = 0;
  logic [NCH-1:0] en = '0;
  logic [1:0] wr_ch = '0;
  logic [15:0] wr_period = '0, wr_high = '0;
  logic [NCH-1:0] out, tick, pending;
  int n_chk = 0, n_fail = 0;
  int m_p[NCH], m_h[NCH], m_sp[NCH], m_sh[NCH], m_cnt[NCH];
  bit m_run[NCH], m_pend[NCH];
  logic [NCH-1:0] e_out, e_tick, e_pend;

  freqdiv_prog #(.NCH(NCH), .WIDTH(16), .CHW(2), .DEF_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period(wr_period), .wr_high(wr_high), .out(out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < NCH; i++) begin
      m_p[i] = 2; m_h[i] = 1; m_sp[i] = 2; m_sh[i] = 1;
      m_cnt[i] = 0; m_run[i] = 0; m_pend[i] = 0;
    end
    e_out = '0; e_tick = '0; e_pend = '0;
  endtask

  // one clock of the reference: a period ends on the last count or on sync; settings land at a period end or when not counting
  task automatic model();
    for (int i = 0; i < NCH; i++) begin
      bit live, period_end;
      live = m_run[i] && en[i];
      period_end = live && (sync || m_cnt[i] == m_p[i] - 1);
      if (wr_en && int'(wr_ch) == i) begin
        m_sp[i] = int'(wr_period);
        m_sh[i] = int'(wr_high);
        if (live && !period_end) m_pend[i] = 1;
      end
      if (!live || period_end) begin
        m_p[i] = m_sp[i];
        m_h[i] = m_sh[i];
        m_pend[i] = 0;
      end
      m_cnt[i] = (live && !period_end) ? m_cnt[i] + 1 : 0;
      m_run[i] = en[i] && m_p[i] >= 2;
      e_tick[i] = period_end && m_run[i];
      e_out[i] = m_run[i] && m_cnt[i] < m_h[i];
      e_pend[i] = m_pend[i];
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("out", 32'(out), 32'(e_out));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("pending", 32'(pending), 32'(e_pend));
  endtask

  task automatic wr(input int ch, input int p, input int h);
    wr_en = 1; wr_ch = 2'(ch); wr_period = 16'(p); wr_high = 16'(h);
    step();
    wr_en = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic align(input int ch, input int c);
    for (int k = 0; k < 20 && m_cnt[ch] != c; k++) step();
    chk("align", 32'(m_cnt[ch]), 32'(c));
  endtask

  initial begin
    mreset();
    #12;
    chk("rst_out", 32'(out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pending", 32'(pending), 0);
    @(negedge clk) reset = 1;
    en = 3'b001;
    run(8);
    wr(1, 5, 2);
    en = 3'b011;
    run(12);
    align(1, 1);
    wr(1, 3, 1);
    run(10);
    wr(2, 4, 2);
    en = 3'b111;
    run(2);
    align(2, 3);
    wr(2, 6, 3);
    run(14);
    wr(0, 4, 2);
    run(3);
    wr(1, 6, 3);
    run(9);
    sync = 1;
    step();
    sync = 0;
    run(13);
    align(0, 3);
    sync = 1;
    step();
    sync = 0;
    run(6);
    wr(0, 4, 0);
    wr(1, 5, 7);
    wr(2, 1, 1);
    run(12);
    wr(3, 9, 4);
    run(6);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) en = 3'($urandom);
      sync = $urandom_range(0, 19) == 0;
      wr_en = $urandom_range(0, 5) == 0;
      wr_ch = 2'($urandom_range(0, 3));
      wr_period = 16'($urandom_range(0, 9));
      wr_high = 16'($urandom_range(0, 10));
      step();
    end
    wr_en = 0; sync = 0; en = 3'b111;
    wr(0, 7, 3);
    run(3);
    #3 reset = 0;
    #1;
    chk("async_out", 32'(out), 0);
    chk("async_tick", 32'(tick), 0);
    chk("async_pending", 32'(pending), 0);
    mreset();
    @(negedge clk) reset = 1;
    run(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
